// File: rtl/audio_frame_pkg.sv
// Shared constants, FSM state type and width helper for the audio frame packer.
package audio_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         HDR_LEN   = 4;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    HDR,
    PAYLOAD,
    GAP
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock first-word-fall-through FIFO holding complete multi-channel sample sets.
module audio_sample_fifo
  import audio_frame_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  level_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/audio_frame_packer.sv
// Buffers PCM sample sets and streams fixed-length frames (4-byte header + payload)
// as a vsync/href byte stream with backpressure, overflow tracking and optional mono mix.
module audio_frame_packer
  import audio_frame_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int SAMPLE_W      = 16,
  parameter int FRAME_SAMPLES = 256,
  parameter int FIFO_DEPTH    = 1024,
  parameter int GAP_CYCLES    = 16
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         sample_vld,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  input  logic                         mix_mono,
  input  logic                         out_ready,
  output logic                         frame_vsync,
  output logic                         frame_href,
  output logic [7:0]                   frame_data,
  output logic [7:0]                   frame_seq,
  output logic [15:0]                  ovf_cnt,
  output logic [clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SET_W  = clog2(FRAME_SAMPLES) + 1;
  localparam int GAP_W  = clog2(GAP_CYCLES) + 1;
  localparam int BPS    = SAMPLE_W / 8;
  localparam int CH_LOG = clog2(NUM_CH);
  localparam int SUM_W  = SAMPLE_W + CH_LOG;

  state_e             state_q, state_d;
  logic [1:0]         hdr_idx_q, hdr_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [3:0]         ch_idx_q, ch_idx_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         seq_q, seq_d;
  logic               mode_q, mode_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic               ovf_hdr_q, ovf_hdr_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d;

  logic [NUM_CH*SAMPLE_W-1:0] fifo_rdata;
  logic                       fifo_full, fifo_empty, fifo_pop, drop;
  logic [clog2(FIFO_DEPTH):0] fifo_lvl;

  logic signed [SUM_W-1:0]    mix_sum, mix_shift;
  logic [SAMPLE_W-1:0]        cur_sample, shifted;
  logic [3:0]                 ch_out;
  logic                       xfer, last_byte, last_ch, last_set, gap_done;

  assign drop = sample_vld && fifo_full;

  audio_sample_fifo #(
    .WIDTH (NUM_CH*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .push_i  (sample_vld),
    .pop_i   (fifo_pop),
    .wdata_i (sample_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  // Widened signed sum cannot overflow; the arithmetic shift floors the average.
  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mix_sum = mix_sum + SUM_W'($signed(fifo_rdata[c*SAMPLE_W +: SAMPLE_W]));
    end
    mix_shift = mix_sum >>> CH_LOG;
  end

  assign ch_out     = mode_q ? 4'd1 : 4'(NUM_CH);
  assign cur_sample = mode_q ? mix_shift[SAMPLE_W-1:0]
                             : fifo_rdata[int'(ch_idx_q)*SAMPLE_W +: SAMPLE_W];
  assign shifted    = cur_sample >> (8 * (BPS - 1 - int'(byte_idx_q)));

  assign frame_vsync = (state_q == VSYNC);
  assign frame_href  = (state_q == HDR) || (state_q == PAYLOAD);
  assign xfer        = frame_href && out_ready;
  assign last_byte   = (byte_idx_q == 2'(BPS - 1));
  assign last_ch     = (ch_idx_q == ch_out - 4'd1);
  assign last_set    = (set_cnt_q == SET_W'(FRAME_SAMPLES - 1));
  assign gap_done    = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    frame_data = 8'h00;
    if (state_q == HDR) begin
      case (hdr_idx_q)
        2'd0:    frame_data = SYNC_BYTE;
        2'd1:    frame_data = seq_q;
        2'd2:    frame_data = 8'(ch_out);
        default: frame_data = {7'd0, ovf_hdr_q};
      endcase
    end else if (state_q == PAYLOAD) begin
      frame_data = shifted[7:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    byte_idx_d = byte_idx_q;
    ch_idx_d   = ch_idx_q;
    set_cnt_d  = set_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    seq_d      = seq_q;
    mode_d     = mode_q;
    ovf_hdr_d  = ovf_hdr_q;
    fifo_pop   = 1'b0;
    ovf_flag_d = ((state_q == VSYNC) ? 1'b0 : ovf_flag_q) | drop;
    ovf_cnt_d  = (drop && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;

    case (state_q)
      IDLE: begin
        if (fifo_lvl >= ($bits(fifo_lvl))'(FRAME_SAMPLES)) state_d = VSYNC;
      end
      VSYNC: begin
        mode_d    = mix_mono;
        ovf_hdr_d = ovf_flag_q;
        hdr_idx_d = 2'd0;
        state_d   = HDR;
      end
      HDR: begin
        if (xfer) begin
          if (hdr_idx_q == 2'(HDR_LEN - 1)) begin
            byte_idx_d = '0;
            ch_idx_d   = '0;
            set_cnt_d  = '0;
            state_d    = PAYLOAD;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (!last_byte) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            byte_idx_d = '0;
            if (!last_ch) begin
              ch_idx_d = ch_idx_q + 4'd1;
            end else begin
              ch_idx_d = '0;
              fifo_pop = 1'b1;
              if (last_set) begin
                gap_cnt_d = '0;
                seq_d     = seq_q + 8'd1;
                state_d   = GAP;
              end else begin
                set_cnt_d = set_cnt_q + 1'b1;
              end
            end
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_idx_q  <= '0;
      byte_idx_q <= '0;
      ch_idx_q   <= '0;
      set_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      seq_q      <= '0;
      mode_q     <= 1'b0;
      ovf_flag_q <= 1'b0;
      ovf_hdr_q  <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      byte_idx_q <= byte_idx_d;
      ch_idx_q   <= ch_idx_d;
      set_cnt_q  <= set_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      seq_q      <= seq_d;
      mode_q     <= mode_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_hdr_q  <= ovf_hdr_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign frame_seq  = seq_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign fifo_level = fifo_lvl;

endmodule

// File: tb/tb_audio_frame_packer.sv
// Scoreboard bench for audio_frame_packer: expected frame bytes are queued as sets are
// driven and compared against every accepted byte.
module tb_audio_frame_packer;

  localparam int NUM_CH        = 2;
  localparam int SAMPLE_W      = 16;
  localparam int FRAME_SAMPLES = 4;
  localparam int FIFO_DEPTH    = 8;
  localparam int GAP_CYCLES    = 2;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_vld = 1'b0;
  logic [31:0] sample_data = '0;
  logic        mix_mono = 1'b0;
  logic        out_ready = 1'b1;
  logic        frame_vsync, frame_href;
  logic [7:0]  frame_data, frame_seq;
  logic [15:0] ovf_cnt;
  logic [3:0]  fifo_level;

  int          checks = 0;
  int          failures = 0;
  int          vsyncCount = 0;
  int          expFrames = 0;
  int          byteCount = 0;
  int          maxLevel = 0;
  logic [7:0]  bseq = '0;
  logic [7:0]  expQ[$];

  audio_frame_packer #(
    .NUM_CH        (NUM_CH),
    .SAMPLE_W      (SAMPLE_W),
    .FRAME_SAMPLES (FRAME_SAMPLES),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .GAP_CYCLES    (GAP_CYCLES)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .sample_vld  (sample_vld),
    .sample_data (sample_data),
    .mix_mono    (mix_mono),
    .out_ready   (out_ready),
    .frame_vsync (frame_vsync),
    .frame_href  (frame_href),
    .frame_data  (frame_data),
    .frame_seq   (frame_seq),
    .ovf_cnt     (ovf_cnt),
    .fifo_level  (fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Floor average of the two signed channels, computed in plain integers.
  function automatic logic [15:0] mixModel(input logic [31:0] s);
    int a, b, t;
    a = int'($signed(s[15:0]));
    b = int'($signed(s[31:16]));
    t = (a + b) >>> 1;
    return t[15:0];
  endfunction

  task automatic expectFrame(input bit mono, input bit ovf,
                             input logic [31:0] s0, input logic [31:0] s1,
                             input logic [31:0] s2, input logic [31:0] s3);
    logic [31:0] sets [4];
    logic [15:0] m;
    sets = '{s0, s1, s2, s3};
    expQ.push_back(8'hA5);
    expQ.push_back(bseq);
    expQ.push_back(mono ? 8'd1 : 8'd2);
    expQ.push_back({7'd0, ovf});
    for (int i = 0; i < 4; i++) begin
      if (mono) begin
        m = mixModel(sets[i]);
        expQ.push_back(m[15:8]);
        expQ.push_back(m[7:0]);
      end else begin
        expQ.push_back(sets[i][15:8]);
        expQ.push_back(sets[i][7:0]);
        expQ.push_back(sets[i][31:24]);
        expQ.push_back(sets[i][23:16]);
      end
    end
    bseq++;
    expFrames++;
  endtask

  // Drive one set; it lands on the next rising edge.
  task automatic applyStimulus(input logic [31:0] d);
    sample_vld  = 1'b1;
    sample_data = d;
    @(posedge sys_clk);
    #1;
    sample_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst        = 1'b1;
    sample_vld = 1'b0;
    out_ready  = 1'b1;
    mix_mono   = 1'b0;
    idle(2);
    rst = 1'b0;
    expQ.delete();
    bseq       = '0;
    vsyncCount = 0;
    expFrames  = 0;
    byteCount  = 0;
    maxLevel   = 0;
  endtask

  task automatic waitIdle(input int budget, input bit toggle);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge sys_clk);
      #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    idle(GAP_CYCLES + 3);
  endtask

  // Every accepted byte is checked against the scoreboard head.
  always @(negedge sys_clk) begin
    if (rst !== 1'b1) begin
      if (frame_vsync) vsyncCount++;
      if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
      if (frame_href && out_ready) begin
        byteCount++;
        if (expQ.size() == 0) checkOutput("byte_unexpected", 32'(frame_data), 32'h100);
        else                  checkOutput("byte", 32'(frame_data), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] s [4];

    idle(1);
    doReset();
    checkOutput("rst_href", 32'(frame_href), 32'd0);
    checkOutput("rst_vsync", 32'(frame_vsync), 32'd0);
    checkOutput("rst_data", 32'(frame_data), 32'd0);
    checkOutput("rst_seq", 32'(frame_seq), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_cnt), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);

    // Scenario 1: stereo frame plus vsync/href latency from the completing write.
    for (int i = 0; i < 4; i++) s[i] = {16'(2*i + 2), 16'(2*i + 1)};
    expectFrame(1'b0, 1'b0, s[0], s[1], s[2], s[3]);
    for (int i = 0; i < 3; i++) applyStimulus(s[i]);
    applyStimulus(s[3]);
    @(negedge sys_clk);
    checkOutput("vsync_edgeN", 32'(frame_vsync), 32'd0);
    @(negedge sys_clk);
    checkOutput("vsync_edgeN1", 32'(frame_vsync), 32'd1);
    checkOutput("href_edgeN1", 32'(frame_href), 32'd0);
    @(negedge sys_clk);
    checkOutput("vsync_edgeN2", 32'(frame_vsync), 32'd0);
    checkOutput("href_edgeN2", 32'(frame_href), 32'd1);
    @(posedge sys_clk);
    #1;
    waitIdle(200, 1'b0);
    checkOutput("s1_seq", 32'(frame_seq), 32'd1);
    checkOutput("s1_vsyncs", 32'(vsyncCount), 32'(expFrames));
    checkOutput("s1_bytes", 32'(byteCount), 32'd20);
    checkOutput("s1_level", 32'(fifo_level), 32'd0);

    // Scenario 2: mono mix; a mix_mono change mid-frame must not apply.
    mix_mono = 1'b1;
    expectFrame(1'b1, 1'b0, 32'hFFFF_0000, 32'h7FFF_7FFF, 32'h0003_0001, 32'h8000_8000);
    applyStimulus(32'hFFFF_0000);
    applyStimulus(32'h7FFF_7FFF);
    applyStimulus(32'h0003_0001);
    applyStimulus(32'h8000_8000);
    idle(4);
    mix_mono = 1'b0;
    waitIdle(200, 1'b0);
    checkOutput("s2_seq", 32'(frame_seq), 32'd2);

    // Scenario 3: overflow with downstream stalled.
    doReset();
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) s[i] = {16'h3000 + 16'(4*f + i), 16'h0100 + 16'(4*f + i)};
      expectFrame(1'b0, f[0], s[0], s[1], s[2], s[3]);
      for (int i = 0; i < 4; i++) applyStimulus(s[i]);
    end
    applyStimulus(32'hDEAD_BEEF);
    applyStimulus(32'hCAFE_F00D);
    checkOutput("s3_ovf", 32'(ovf_cnt), 32'd2);
    checkOutput("s3_level_full", 32'(fifo_level), 32'd8);
    out_ready = 1'b1;
    waitIdle(300, 1'b0);
    for (int i = 0; i < 4; i++) s[i] = {16'h5500 + 16'(i), 16'h6600 + 16'(i)};
    expectFrame(1'b0, 1'b0, s[0], s[1], s[2], s[3]);
    for (int i = 0; i < 4; i++) applyStimulus(s[i]);
    waitIdle(200, 1'b0);
    checkOutput("s3_ovf_hold", 32'(ovf_cnt), 32'd2);
    checkOutput("s3_seq", 32'(frame_seq), 32'd3);

    // Scenario 4: out_ready toggling every cycle.
    doReset();
    for (int i = 0; i < 4; i++) s[i] = {16'(2*i + 2), 16'(2*i + 1)};
    expectFrame(1'b0, 1'b0, s[0], s[1], s[2], s[3]);
    for (int i = 0; i < 4; i++) applyStimulus(s[i]);
    waitIdle(200, 1'b1);
    checkOutput("s4_bytes", 32'(byteCount), 32'd20);
    checkOutput("s4_seq", 32'(frame_seq), 32'd1);

    // Scenario 5: reset in the middle of the payload.
    doReset();
    for (int i = 0; i < 4; i++) s[i] = {16'hA000 + 16'(i), 16'hB000 + 16'(i)};
    expectFrame(1'b0, 1'b0, s[0], s[1], s[2], s[3]);
    for (int i = 0; i < 4; i++) applyStimulus(s[i]);
    begin
      int n;
      n = 0;
      while (byteCount < 11 && n < 200) begin
        @(posedge sys_clk);
        #1;
        n++;
      end
      checkOutput("s5_reach_byte7", 32'(byteCount), 32'd11);
    end
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    bseq = '0;
    checkOutput("s5_href", 32'(frame_href), 32'd0);
    checkOutput("s5_level", 32'(fifo_level), 32'd0);
    checkOutput("s5_seq", 32'(frame_seq), 32'd0);
    checkOutput("s5_ovf", 32'(ovf_cnt), 32'd0);
    for (int i = 0; i < 4; i++) s[i] = {16'h1234 + 16'(i), 16'h4321 + 16'(i)};
    expectFrame(1'b0, 1'b0, s[0], s[1], s[2], s[3]);
    for (int i = 0; i < 4; i++) applyStimulus(s[i]);
    waitIdle(200, 1'b0);
    checkOutput("s5_seq_after", 32'(frame_seq), 32'd1);

    // Scenario 6: 300 frames at one set per 10 cycles; sequence wraps.
    doReset();
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < 4; i++) s[i] = $urandom;
      expectFrame(1'b0, 1'b0, s[0], s[1], s[2], s[3]);
      for (int i = 0; i < 4; i++) begin
        applyStimulus(s[i]);
        idle(9);
      end
    end
    waitIdle(400, 1'b0);
    checkOutput("s6_seq", 32'(frame_seq), 32'(300 % 256));
    checkOutput("s6_ovf", 32'(ovf_cnt), 32'd0);
    checkOutput("s6_level_bound", 32'(maxLevel <= 8), 32'd1);
    checkOutput("s6_vsyncs", 32'(vsyncCount), 32'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
